// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arb_pkg;

    localparam int c_addr_w_default = 8;
    localparam int c_data_w_default = 16;
    localparam int c_starve_w       = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        LOCKED  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter_if
// Description : CPU, loader and memory bus bundle for data_mem_arbiter.
//               DATA_MEM_ARB_LOCK_EN adds the ldr_lock signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_default,
    parameter int DATA_W = c_data_w_default
) ();

    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ldr_req;
    logic              ldr_wr;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_done;
    logic [DATA_W-1:0] ldr_rdata;
`ifdef DATA_MEM_ARB_LOCK_EN
    logic              ldr_lock;
`endif

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

`ifdef DATA_MEM_ARB_LOCK_EN
    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_wr, ldr_addr, ldr_wdata, ldr_lock,
        input  mem_rdata,
        output cpu_done, cpu_rdata, cpu_stall,
        output ldr_done, ldr_rdata,
        output mem_addr, mem_wr, mem_wdata, busy
    );
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output ldr_req, ldr_wr, ldr_addr, ldr_wdata, ldr_lock,
        output mem_rdata,
        input  cpu_done, cpu_rdata, cpu_stall,
        input  ldr_done, ldr_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy
    );
`else
    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_wr, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_done, cpu_rdata, cpu_stall,
        output ldr_done, ldr_rdata,
        output mem_addr, mem_wr, mem_wdata, busy
    );
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output ldr_req, ldr_wr, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_done, cpu_rdata, cpu_stall,
        input  ldr_done, ldr_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy
    );
`endif

endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : arb_select
// Description : Combinational winner selection and next starvation count.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_select
    import data_mem_arb_pkg::*;
#(
    parameter int CPU_PRIORITY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  cpu_req,
    input  logic                  ldr_req,
    input  logic [c_starve_w-1:0] starve_cnt,
    input  owner_t                last_owner,
    output logic                  grant,
    output owner_t                winner,
    output logic [c_starve_w-1:0] starve_nxt
);

    localparam logic [c_starve_w-1:0] c_starve_limit = c_starve_w'(STARVE_LIMIT);
    localparam logic [c_starve_w-1:0] c_one          = c_starve_w'(1);

    always_comb begin
        grant      = cpu_req | ldr_req;
        winner     = OWN_CPU;
        starve_nxt = '0;

        if (cpu_req && ldr_req) begin
            if (CPU_PRIORITY != 0) begin
                winner = (starve_cnt == c_starve_limit) ? OWN_LDR : OWN_CPU;
            end else begin
                winner = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
            end
        end else if (ldr_req) begin
            winner = OWN_LDR;
        end

        // Count only CPU wins taken while the loader was left waiting.
        if (ldr_req && (winner == OWN_CPU)) begin
            starve_nxt = (starve_cnt == c_starve_limit) ? starve_cnt : starve_cnt + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Serialises CPU and loader accesses to a single-port synchronous
//               data memory. Optional macro DATA_MEM_ARB_LOCK_EN adds ldr_lock.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = c_addr_w_default,
    parameter int DATA_W       = c_data_w_default,
    parameter int CPU_PRIORITY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave bus
);

    arb_state_t            r_state;
    owner_t                r_owner;
    owner_t                r_last_owner;
    logic [c_starve_w-1:0] r_starve_cnt;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_mem_wr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_cpu_done;
    logic                  r_ldr_done;

    logic                  w_cpu_req;
    logic                  w_grant;
    owner_t                w_winner;
    logic [c_starve_w-1:0] w_starve_nxt;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic                  w_sel_wr;
    logic [DATA_W-1:0]     w_sel_wdata;

`ifdef DATA_MEM_ARB_LOCK_EN
    // While the loader holds the lock the CPU is invisible to arbitration.
    assign w_cpu_req = bus.cpu_req & (r_state != LOCKED);
`else
    assign w_cpu_req = bus.cpu_req;
`endif

    arb_select #(
        .CPU_PRIORITY (CPU_PRIORITY),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_select (
        .cpu_req    (w_cpu_req),
        .ldr_req    (bus.ldr_req),
        .starve_cnt (r_starve_cnt),
        .last_owner (r_last_owner),
        .grant      (w_grant),
        .winner     (w_winner),
        .starve_nxt (w_starve_nxt)
    );

    assign w_sel_addr  = (w_winner == OWN_CPU) ? bus.cpu_addr  : bus.ldr_addr;
    assign w_sel_wr    = (w_winner == OWN_CPU) ? bus.cpu_wr    : bus.ldr_wr;
    assign w_sel_wdata = (w_winner == OWN_CPU) ? bus.cpu_wdata : bus.ldr_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_LDR;
            r_starve_cnt <= '0;
            r_mem_addr   <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_wdata  <= '0;
            r_cpu_done   <= 1'b0;
            r_ldr_done   <= 1'b0;
        end else begin
            // Write enable and done pulses live for exactly one state.
            r_mem_wr   <= 1'b0;
            r_cpu_done <= 1'b0;
            r_ldr_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_starve_cnt <= w_starve_nxt;
                    if (w_grant) begin
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wr     <= w_sel_wr;
                        r_mem_wdata  <= w_sel_wdata;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_cpu_done <= (r_owner == OWN_CPU);
                    r_ldr_done <= (r_owner == OWN_LDR);
                    r_state    <= CAPTURE;
                end

                CAPTURE: begin
`ifdef DATA_MEM_ARB_LOCK_EN
                    if ((r_owner == OWN_LDR) && bus.ldr_lock) begin
                        r_state <= LOCKED;
                    end else begin
                        r_state <= IDLE;
                    end
`else
                    r_state <= IDLE;
`endif
                end

`ifdef DATA_MEM_ARB_LOCK_EN
                LOCKED: begin
                    // starve_cnt is deliberately left untouched here.
                    if (!bus.ldr_lock) begin
                        r_state <= IDLE;
                    end else if (w_grant) begin
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wr     <= w_sel_wr;
                        r_mem_wdata  <= w_sel_wdata;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_state      <= ISSUE;
                    end
                end
`endif

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_done  = r_cpu_done;
    assign bus.ldr_done  = r_ldr_done;
    // Read data comes straight from the memory in the capture cycle.
    assign bus.cpu_rdata = r_cpu_done ? bus.mem_rdata : '0;
    assign bus.ldr_rdata = r_ldr_done ? bus.mem_rdata : '0;
    assign bus.cpu_stall = bus.cpu_req & ~r_cpu_done;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Scoreboard bench for data_mem_arbiter with a synchronous memory
//               model; the lock scenario runs when DATA_MEM_ARB_LOCK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic          owner;
        logic          is_rd;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();

    data_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .CPU_PRIORITY(1), .STARVE_LIMIT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    data_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .CPU_PRIORITY(0), .STARVE_LIMIT(4)
    ) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr)
    );

    logic [DW-1:0] tb_mem    [256];
    logic [DW-1:0] model_mem [256];
    exp_t          sb [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_mem_wr = 0;
    logic          prev_cpu_done = 1'b0;
    logic          prev_ldr_done = 1'b0;

    // Synchronous-read memory: address sampled on the edge, data next cycle.
    always @(posedge clk) begin
        bus.mem_rdata <= tb_mem[bus.mem_addr];
        if (bus.mem_wr) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic own, input logic rd, input logic [DW-1:0] d);
        exp_t e;
        e.owner = own;
        e.is_rd = rd;
        e.rdata = d;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit ldr);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ldr ? bus.ldr_done : bus.cpu_done) break;
        end
        check_value(ldr ? "ldr_done_seen" : "cpu_done_seen", ldr ? bus.ldr_done : bus.cpu_done, 1);
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        return {8'(i) ^ 8'hA5, 8'(i)};
    endfunction

    // Scoreboard monitor for the priority instance.
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_wr) n_mem_wr++;
        if (bus.cpu_done || bus.ldr_done) begin
            check_value("single_done", bus.cpu_done & bus.ldr_done, 0);
            check_value("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_value("done_owner", bus.ldr_done, e.owner);
                if (e.is_rd)
                    check_value("rdata", bus.ldr_done ? bus.ldr_rdata : bus.cpu_rdata, e.rdata);
            end
        end
        if (bus.cpu_done) check_value("cpu_done_width", prev_cpu_done, 0);
        if (bus.ldr_done) check_value("ldr_done_width", prev_ldr_done, 0);
        prev_cpu_done = bus.cpu_done;
        prev_ldr_done = bus.ldr_done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int        cnt;
        int        cidx;
        int        lidx;
        int        ndone;
        logic [9:0] pri_order;
        logic [5:0] rr_order;
        int        wr_base;

        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 0; bus.ldr_wr = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        bus_rr.cpu_req = 0; bus_rr.cpu_wr = 0; bus_rr.cpu_addr = '0; bus_rr.cpu_wdata = '0;
        bus_rr.ldr_req = 0; bus_rr.ldr_wr = 0; bus_rr.ldr_addr = '0; bus_rr.ldr_wdata = '0;
        bus_rr.mem_rdata = '0;
`ifdef DATA_MEM_ARB_LOCK_EN
        bus.ldr_lock = 0;
        bus_rr.ldr_lock = 0;
`endif
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]    <= init_word(i);
            model_mem[i]  = init_word(i);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_mem_wr",    bus.mem_wr, 0);
        check_value("rst_mem_addr",  bus.mem_addr, 0);
        check_value("rst_mem_wdata", bus.mem_wdata, 0);
        check_value("rst_cpu_done",  bus.cpu_done, 0);
        check_value("rst_ldr_done",  bus.ldr_done, 0);
        check_value("rst_cpu_rdata", bus.cpu_rdata, 0);
        check_value("rst_busy",      bus.busy, 0);
        rst_n = 1;

        // Reset asserted during ISSUE of a loader write
        @(posedge clk); #1;
        bus.ldr_req = 1; bus.ldr_wr = 1; bus.ldr_addr = 8'h10; bus.ldr_wdata = 16'hABCD;
        @(posedge clk); #1;
        check_value("issue_mem_wr",   bus.mem_wr, 1);
        check_value("issue_mem_addr", bus.mem_addr, 8'h10);
        check_value("issue_busy",     bus.busy, 1);
        bus.ldr_req = 0; bus.ldr_wr = 0;
        rst_n = 0;
        #1;
        check_value("abort_mem_wr",    bus.mem_wr, 0);
        check_value("abort_mem_addr",  bus.mem_addr, 0);
        check_value("abort_mem_wdata", bus.mem_wdata, 0);
        check_value("abort_busy",      bus.busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.ldr_done) cnt++;
        end
        check_value("abort_no_done",  cnt, 0);
        check_value("abort_no_write", tb_mem[8'h10], model_mem[8'h10]);

        // CPU read of 0x9A, cycle-accurate
        tb_mem[8'h9A] <= 16'h1234;
        model_mem[8'h9A] = 16'h1234;
        @(posedge clk); #1;
        push_exp(OWN_CPU, 1, 16'h1234);
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 8'h9A;
        @(negedge clk);
        check_value("c0_stall", bus.cpu_stall, 1);
        check_value("c0_busy",  bus.busy, 0);
        @(negedge clk);
        check_value("c1_mem_addr", bus.mem_addr, 8'h9A);
        check_value("c1_mem_wr",   bus.mem_wr, 0);
        check_value("c1_stall",    bus.cpu_stall, 1);
        check_value("c1_cpu_done", bus.cpu_done, 0);
        @(negedge clk);
        check_value("c2_cpu_done",  bus.cpu_done, 1);
        check_value("c2_cpu_rdata", bus.cpu_rdata, 16'h1234);
        check_value("c2_stall",     bus.cpu_stall, 0);
        check_value("c2_ldr_done",  bus.ldr_done, 0);
        bus.cpu_req = 0;

        // Loader write 0x55 <- 0xBEEF, then CPU read-back
        wr_base = n_mem_wr;
        @(posedge clk); #1;
        push_exp(OWN_LDR, 0, '0);
        model_mem[8'h55] = 16'hBEEF;
        bus.ldr_req = 1; bus.ldr_wr = 1; bus.ldr_addr = 8'h55; bus.ldr_wdata = 16'hBEEF;
        wait_done(1);
        bus.ldr_req = 0; bus.ldr_wr = 0;
        @(posedge clk); #1;
        push_exp(OWN_CPU, 1, model_mem[8'h55]);
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 8'h55;
        wait_done(0);
        bus.cpu_req = 0;
        check_value("ldr_wr_once", n_mem_wr - wr_base, 1);

        // CPU priority with starvation limit 4, both requests held
        @(posedge clk); #1;
        cidx = 0; lidx = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                push_exp(OWN_LDR, 1, model_mem[8'h80 + lidx]);
                lidx++;
            end else begin
                push_exp(OWN_CPU, 1, model_mem[8'h20 + cidx]);
                cidx++;
            end
        end
        cidx = 0; lidx = 0; ndone = 0; pri_order = '0;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 8'h20;
        bus.ldr_req = 1; bus.ldr_wr = 0; bus.ldr_addr = 8'h80;
        for (int cyc = 0; cyc < 80 && ndone < 10; cyc++) begin
            @(negedge clk);
            if (bus.cpu_done) begin
                ndone++; cidx++;
                bus.cpu_addr = 8'(32'h20 + cidx);
            end
            if (bus.ldr_done) begin
                pri_order[ndone] = 1'b1;
                ndone++; lidx++;
                bus.ldr_addr = 8'(32'h80 + lidx);
            end
            if (ndone >= 10) begin
                bus.cpu_req = 0;
                bus.ldr_req = 0;
            end
        end
        bus.cpu_req = 0; bus.ldr_req = 0;
        check_value("pri_grant_count", ndone, 10);
        check_value("pri_order", pri_order, 10'b10_0001_0000);

        // Round-robin instance: strict alternation from the CPU
        @(posedge clk); #1;
        ndone = 0; rr_order = '0;
        bus_rr.cpu_req = 1; bus_rr.ldr_req = 1;
        for (int cyc = 0; cyc < 60 && ndone < 6; cyc++) begin
            @(negedge clk);
            check_value("rr_single_done", bus_rr.cpu_done & bus_rr.ldr_done, 0);
            if (bus_rr.ldr_done) rr_order[ndone] = 1'b1;
            if (bus_rr.cpu_done || bus_rr.ldr_done) ndone++;
            if (ndone >= 6) begin
                bus_rr.cpu_req = 0;
                bus_rr.ldr_req = 0;
            end
        end
        bus_rr.cpu_req = 0; bus_rr.ldr_req = 0;
        check_value("rr_grant_count", ndone, 6);
        check_value("rr_order", rr_order, 6'b10_1010);

`ifdef DATA_MEM_ARB_LOCK_EN
        // Loader lock across three writes while the CPU waits
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            push_exp(OWN_LDR, 0, '0);
            model_mem[8'h60 + k] = 16'hC000 + 16'(k);
        end
        bus.ldr_lock = 1;
        bus.ldr_req = 1; bus.ldr_wr = 1; bus.ldr_addr = 8'h60; bus.ldr_wdata = 16'hC000;
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 8'h20;
        lidx = 0; cnt = 0;
        for (int cyc = 0; cyc < 60 && lidx < 3; cyc++) begin
            @(negedge clk);
            if (bus.cpu_done) cnt++;
            if (bus.ldr_done) begin
                lidx++;
                check_value("lock_cpu_stall", bus.cpu_stall, 1);
                bus.ldr_addr  = 8'(32'h60 + lidx);
                bus.ldr_wdata = 16'(32'hC000 + lidx);
                if (lidx == 3) begin
                    bus.ldr_req = 0;
                    bus.ldr_wr  = 0;
                end
            end
        end
        check_value("lock_ldr_done_count", lidx, 3);
        check_value("lock_no_cpu_done", cnt, 0);
        push_exp(OWN_CPU, 1, model_mem[8'h20]);
        @(negedge clk);
        check_value("locked_busy",  bus.busy, 1);
        check_value("locked_stall", bus.cpu_stall, 1);
        bus.ldr_lock = 0;
        @(negedge clk);
        check_value("unlock_idle", bus.busy, 0);
        @(negedge clk);
        check_value("post_lock_cpu_addr", bus.mem_addr, 8'h20);
        @(negedge clk);
        check_value("post_lock_cpu_done", bus.cpu_done, 1);
        bus.cpu_req = 0;
        for (int k = 0; k < 3; k++)
            check_value("lock_mem_write", tb_mem[8'h60 + k], model_mem[8'h60 + k]);
`endif

        repeat (3) @(negedge clk);
        check_value("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
